// File: rtl/skew_a_10x.sv
// Diagonal skew stage feeding the systolic MMU: lane k of each column vector is delayed by k extra cycles.
// Optional `SKEW_VEC_COUNT_EN` adds a 16-bit saturating vec_count of vectors accepted since leaving IDLE.
module skew_a_10x #(
    parameter int VAR_SIZE = 8,
    parameter int MMU_SIZE = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         stop,
    input  logic [VAR_SIZE*MMU_SIZE-1:0] B1,
    input  logic                         in_valid,
    output logic [VAR_SIZE*MMU_SIZE-1:0] B1_skew,
    output logic [MMU_SIZE-1:0]          lane_valid,
    output logic                         busy,
    output logic                         done
`ifdef SKEW_VEC_COUNT_EN
    ,
    output logic [15:0]                  vec_count
`endif
);

    localparam int CNT_W = (MMU_SIZE > 2) ? $clog2(MMU_SIZE) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(MMU_SIZE - 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic             done_d;

    // Per-lane shift chains; chain k has k+1 stages so lane k leaves k cycles after lane 0.
    for (genvar k = 0; k < MMU_SIZE; k++) begin : g_lane
        logic [VAR_SIZE-1:0] data_q [k+1];
        logic [k:0]          valid_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                // NOTE: the chain storage is reset on purpose: reset must discard in-flight data
                // and the outputs are defined as zero afterwards, so these are not don't-care RAM.
                for (int s = 0; s <= k; s++) begin
                    data_q[s] <= '0;
                end
                valid_q <= '0;
            end else if (!stop) begin
                // NOTE: non-blocking assignments let every stage sample its predecessor's old
                // value, so the whole chain shifts by exactly one position per edge.
                data_q[0]  <= in_valid ? B1[k*VAR_SIZE +: VAR_SIZE] : '0;
                valid_q[0] <= in_valid;
                for (int s = 1; s <= k; s++) begin
                    data_q[s]  <= data_q[s-1];
                    valid_q[s] <= valid_q[s-1];
                end
            end
        end

        assign B1_skew[k*VAR_SIZE +: VAR_SIZE] = data_q[k];
        assign lane_valid[k]                   = valid_q[k];
    end

    // Control FSM: DRAIN lasts until the last lane of the final vector has been presented.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; without them a missed
        // branch would infer a latch.
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (!in_valid) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = '0;
                end
            end
            S_DRAIN: begin
                if (in_valid) begin
                    state_d = S_STREAM;
                end else if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            drain_cnt_q <= '0;
            done        <= 1'b0;
        end else if (!stop) begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            done        <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);

`ifdef SKEW_VEC_COUNT_EN
    logic [15:0] vec_count_d;

    always_comb begin
        vec_count_d = vec_count;
        if (in_valid) begin
            if (state_q == S_IDLE) begin
                vec_count_d = 16'd1;
            end else if (vec_count != 16'hFFFF) begin
                vec_count_d = vec_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec_count <= '0;
        end else if (!stop) begin
            vec_count <= vec_count_d;
        end
    end
`endif

endmodule

// File: tb/tb_skew_a_10x.sv
// Self-checking bench for skew_a_10x: directed scenarios plus randomized traffic against a
// history-based reference model (lane k shows the input accepted k unstalled edges ago).
module tb_skew_a_10x;

    localparam int V = 8;
    localparam int M = 10;
    localparam int W = V * M;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         stop;
    logic [W-1:0] B1;
    logic         in_valid;
    logic [W-1:0] B1_skew;
    logic [M-1:0] lane_valid;
    logic         busy;
    logic         done;
`ifdef SKEW_VEC_COUNT_EN
    logic [15:0]  vec_count;
`endif

    skew_a_10x #(.VAR_SIZE(V), .MMU_SIZE(M)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stop       (stop),
        .B1         (B1),
        .in_valid   (in_valid),
        .B1_skew    (B1_skew),
        .lane_valid (lane_valid),
        .busy       (busy),
        .done       (done)
`ifdef SKEW_VEC_COUNT_EN
        ,
        .vec_count  (vec_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Reference model: history of what was shifted in at each unstalled edge, newest first.
    typedef struct {
        logic         valid;
        logic [W-1:0] data;
    } ent_t;

    ent_t        hist[$];
    bit          m_active = 0;
    int          m_gap    = 0;
    logic        m_done   = 0;
    logic [15:0] m_vc     = '0;

    task automatic model_edge(input logic iv, input logic [W-1:0] v, input logic st, input logic rn);
        ent_t e;
        if (!rn) begin
            hist.delete();
            m_active = 0;
            m_gap    = 0;
            m_done   = 0;
            m_vc     = '0;
        end else if (!st) begin
            e.valid = iv;
            e.data  = iv ? v : '0;
            hist.push_front(e);
            if (hist.size() > M) void'(hist.pop_back());
            m_done = 0;
            if (iv) begin
                m_vc     = !m_active ? 16'd1 : (m_vc == 16'hFFFF ? m_vc : m_vc + 16'd1);
                m_active = 1;
                m_gap    = 0;
            end else if (m_active) begin
                // Idle again once M consecutive empty edges have followed the last vector.
                m_gap++;
                if (m_gap == M) begin
                    m_active = 0;
                    m_done   = 1;
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic [W-1:0] exp_d;
        logic [M-1:0] exp_v;
        exp_d = '0;
        exp_v = '0;
        for (int k = 0; k < M; k++) begin
            if (k < hist.size()) begin
                exp_d[k*V +: V] = hist[k].data[k*V +: V];
                exp_v[k]        = hist[k].valid;
            end
        end
        check("B1_skew", 128'(B1_skew), 128'(exp_d));
        check("lane_valid", 128'(lane_valid), 128'(exp_v));
        check("busy", 128'(busy), 128'(m_active));
        check("done", 128'(done), 128'(m_done));
`ifdef SKEW_VEC_COUNT_EN
        check("vec_count", 128'(vec_count), 128'(m_vc));
`endif
    endtask

    task automatic step(input logic iv, input logic [W-1:0] v, input logic st, input logic rn);
        in_valid = iv;
        B1       = v;
        stop     = st;
        rst_n    = rn;
        @(posedge clk);
        model_edge(iv, v, st, rn);
        #1;
        check_outputs();
    endtask

    function automatic logic [W-1:0] fill(input logic [V-1:0] b);
        logic [W-1:0] r;
        for (int k = 0; k < M; k++) r[k*V +: V] = b;
        return r;
    endfunction

    function automatic logic [W-1:0] rand_vec();
        logic [W-1:0] r;
        for (int k = 0; k < M; k++) r[k*V +: V] = V'($urandom);
        return r;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, rand_vec(), 1'b0, 1'b1);
    endtask

    logic [W-1:0] vtmp;
    int           done_seen;

    initial begin
        in_valid = 0; B1 = '0; stop = 0; rst_n = 0;

        // Reset, including with stop high (reset wins).
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, rand_vec(), 1'b0, 1'b0);
        idle(2);

        // Single vector, lanes 1..10.
        for (int k = 0; k < M; k++) vtmp[k*V +: V] = V'(k + 1);
        step(1'b1, vtmp, 1'b0, 1'b1);
        idle(M + 2);

        // Three back-to-back vectors, with an explicit snapshot after the third edge.
        step(1'b1, fill(8'h11), 1'b0, 1'b1);
        step(1'b1, fill(8'h22), 1'b0, 1'b1);
        step(1'b1, fill(8'h33), 1'b0, 1'b1);
        check("b2b_lanes012", 128'(B1_skew[23:0]), 128'(24'h112233));
        check("b2b_valid", 128'(lane_valid), 128'(10'b0000000111));
        idle(M + 2);

        // stop for 4 cycles mid-DRAIN, with in_valid asserted during stop (must be ignored).
        step(1'b1, rand_vec(), 1'b0, 1'b1);
        idle(3);
        for (int i = 0; i < 4; i++) step(1'b1, rand_vec(), 1'b1, 1'b1);
        idle(M + 2);

        // stop rising while done is high: done must hold until stop falls.
        step(1'b1, rand_vec(), 1'b0, 1'b1);
        idle(M);
        check("done_before_stop", 128'(done), 128'(1'b1));
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b1);
        idle(2);

        // Gap in burst: 1, 2, bubble, 3; lane 9 shows them in order.
        step(1'b1, fill(8'h01), 1'b0, 1'b1);
        step(1'b1, fill(8'h02), 1'b0, 1'b1);
        step(1'b0, fill(8'hEE), 1'b0, 1'b1);
        step(1'b1, fill(8'h03), 1'b0, 1'b1);
        done_seen = 0;
        for (int i = 0; i < M + 3; i++) begin
            step(1'b0, '0, 1'b0, 1'b1);
            if (done) done_seen++;
        end
        check("gap_single_done", 128'(done_seen), 128'(1));

        // Reset mid-STREAM after 5 vectors: everything cleared, no done afterwards.
        for (int i = 0; i < 5; i++) step(1'b1, rand_vec(), 1'b0, 1'b1);
        step(1'b1, rand_vec(), 1'b0, 1'b0);
        check("rst_clear_data", 128'(B1_skew), 128'(0));
        check("rst_clear_busy", 128'(busy), 128'(0));
        done_seen = 0;
        for (int i = 0; i < M + 3; i++) begin
            step(1'b0, '0, 1'b0, 1'b1);
            if (done) done_seen++;
        end
        check("rst_no_done", 128'(done_seen), 128'(0));

        // Signed boundaries: alternating 80/7F, then the inverse pattern.
        for (int k = 0; k < M; k++) vtmp[k*V +: V] = (k % 2 == 0) ? 8'h80 : 8'h7F;
        step(1'b1, vtmp, 1'b0, 1'b1);
        step(1'b1, ~vtmp, 1'b0, 1'b1);
        idle(M + 2);

        // Randomized traffic with stalls and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 60), rand_vec(),
                 ($urandom_range(0, 99) < 15), !($urandom_range(0, 199) == 0));
            if ($urandom_range(0, 49) == 0) idle($urandom_range(M - 2, M + 3));
        end
        idle(M + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
